// File: rtl/repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state encoding
// and default operand width.
package repsub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/repsub_datapath.sv
// Working registers R/D/Q of the divider, the subtract/compare step and the
// magnitude/sign-fix logic that maps the unsigned loop back to signed results.
module repsub_datapath
  import repsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             r_lt_d,
  output logic             d_zero,
  output logic             ovf,
  output logic [WIDTH-1:0] dvd_raw,
  output logic [WIDTH-1:0] quo_fix,
  output logic [WIDTH-1:0] rem_fix
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r, d, q;
  logic             dvd_neg, dvs_neg;
  logic             dvd_sign, dvs_sign;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  // Negating -2^(WIDTH-1) yields the same bit pattern, which read as unsigned
  // is exactly 2^(WIDTH-1), so no extra magnitude bit is needed.
  assign dvd_sign = SIGNED && dividend[WIDTH-1];
  assign dvs_sign = SIGNED && divisor[WIDTH-1];
  assign dvd_mag  = dvd_sign ? -dividend : dividend;
  assign dvs_mag  = dvs_sign ? -divisor  : divisor;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r       <= '0;
      d       <= '0;
      q       <= '0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      dvd_raw <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      r       <= dvd_mag;
      d       <= dvs_mag;
      q       <= '0;
      dvd_neg <= dvd_sign;
      dvs_neg <= dvs_sign;
      dvd_raw <= dividend;
      ovf     <= SIGNED && (dividend == MIN_NEG) && (divisor == '1);
    end else if (step) begin
      r <= r - d;
      q <= q + 1'b1;
    end
  end

  assign r_lt_d  = r < d;
  assign d_zero  = d == '0;
  assign quo_fix = (dvd_neg ^ dvs_neg) ? -q : q;
  assign rem_fix = dvd_neg ? -r : r;

endmodule

// File: rtl/repsub_divider.sv
// Multi-cycle divider by repeated subtraction: IDLE/RUN/DONE control FSM and
// the result registers, around a repsub_datapath instance.
module repsub_divider
  import repsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state, state_next;
  logic             load, step, finish_zero, finish_ok;
  logic             r_lt_d, d_zero, ovf;
  logic [WIDTH-1:0] dvd_raw, quo_fix, rem_fix;

  repsub_datapath #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .dividend (dividend),
    .divisor  (divisor),
    .r_lt_d   (r_lt_d),
    .d_zero   (d_zero),
    .ovf      (ovf),
    .dvd_raw  (dvd_raw),
    .quo_fix  (quo_fix),
    .rem_fix  (rem_fix)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step        = 1'b0;
    finish_zero = 1'b0;
    finish_ok   = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (d_zero) begin
          finish_zero = 1'b1;
          state_next  = DONE;
        end else if (r_lt_d) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quotient/remainder hold from done until the next accepted start; only
  // the flags are cleared on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (load) begin
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (finish_zero) begin
      quotient    <= '1;
      remainder   <= dvd_raw;
      div_by_zero <= 1'b1;
    end else if (finish_ok) begin
      quotient    <= quo_fix;
      remainder   <= rem_fix;
      overflow    <= ovf;
    end
  end

  assign busy = state != IDLE;
  assign done = state == DONE;

endmodule

// File: tb/tb_repsub_divider.sv
// Scoreboard bench for repsub_divider: three instances (16-bit unsigned,
// 16-bit signed, 8-bit signed) checked against an integer-arithmetic model.
module tb_repsub_divider;

  typedef struct {
    int          sel;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s0, s1, s2;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0]  a2, b2;
  logic        bz0, bz1, bz2, dn0, dn1, dn2;
  logic        z0, z1, z2, v0, v1, v2;
  logic [15:0] q0, r0, q1, r1;
  logic [7:0]  q2, r2;

  repsub_divider #(.WIDTH(16), .SIGNED(1'b0)) u_div0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .dividend(a0), .divisor(b0),
    .busy(bz0), .done(dn0), .quotient(q0), .remainder(r0),
    .div_by_zero(z0), .overflow(v0));

  repsub_divider #(.WIDTH(16), .SIGNED(1'b1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .dividend(a1), .divisor(b1),
    .busy(bz1), .done(dn1), .quotient(q1), .remainder(r1),
    .div_by_zero(z1), .overflow(v1));

  repsub_divider #(.WIDTH(8), .SIGNED(1'b1)) u_div2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .dividend(a2), .divisor(b2),
    .busy(bz2), .done(dn2), .quotient(q2), .remainder(r2),
    .div_by_zero(z2), .overflow(v2));

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   scyc[3];
  bit   bprev[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division (truncating toward zero) on sign-extended values.
  function automatic exp_t model(input int sel, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    int     w;
    bit     sg;
    longint m, sa, sbv, qv, rv;
    w   = (sel == 2) ? 8 : 16;
    sg  = (sel != 0);
    m   = (longint'(1) << w) - 1;
    sa  = longint'(a) & m;
    sbv = longint'(b) & m;
    if (sg && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sg && sbv >= (longint'(1) << (w - 1))) sbv = sbv - (longint'(1) << w);
    e.sel = sel;
    if (sbv == 0) begin
      e.q = 32'(m); e.r = 32'(sa & m); e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
    end else begin
      qv    = sa / sbv;
      rv    = sa % sbv;
      e.dz  = 1'b0;
      e.ov  = sg && (qv == (longint'(1) << (w - 1)));
      e.lat = int'((qv < 0) ? -qv : qv) + 1;
      e.q   = 32'(qv & m);
      e.r   = 32'(rv & m);
    end
    return e;
  endfunction

  task automatic mon(input int sel, input logic dn, input logic bs, input logic [31:0] qq,
                     input logic [31:0] rr, input logic dz, input logic ov);
    exp_t e;
    if (bs && !bprev[sel]) scyc[sel] = cyc;
    bprev[sel] = bs;
    if (dn) begin
      if (sb.size() == 0) begin
        check($sformatf("unexpected_done%0d", sel), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("dut_sel", 32'(sel), 32'(e.sel));
        check($sformatf("quotient%0d", sel), qq, e.q);
        check($sformatf("remainder%0d", sel), rr, e.r);
        check($sformatf("div_by_zero%0d", sel), 32'(dz), 32'(e.dz));
        check($sformatf("overflow%0d", sel), 32'(ov), 32'(e.ov));
        check($sformatf("latency%0d", sel), 32'(cyc - scyc[sel]), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, dn0, bz0, {16'b0, q0}, {16'b0, r0}, z0, v0);
    mon(1, dn1, bz1, {16'b0, q1}, {16'b0, r1}, z1, v1);
    mon(2, dn2, bz2, {24'b0, q2}, {24'b0, r2}, z2, v2);
  end

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return bz0;
      1:       return bz1;
      default: return bz2;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0:       begin s0 = st; a0 = a[15:0]; b0 = b[15:0]; end
      1:       begin s1 = st; a1 = a[15:0]; b1 = b[15:0]; end
      default: begin s2 = st; a2 = a[7:0];  b2 = b[7:0];  end
    endcase
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (busy_of(sel) && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 70000) check($sformatf("idle_timeout%0d", sel), 32'd1, 32'd0);
  endtask

  // One operation; a stray start with junk operands is pulsed pulse_k cycles
  // after acceptance to confirm it is ignored while busy.
  task automatic op(input int sel, input logic [31:0] a, input logic [31:0] b, input int pulse_k);
    sb.push_back(model(sel, a, b));
    @(posedge clk); #1;
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, $urandom, $urandom);
    repeat (pulse_k) begin
      @(posedge clk); #1;
    end
    if (busy_of(sel)) begin
      drive(sel, 1'b1, $urandom, $urandom);
      @(posedge clk); #1;
      drive(sel, 1'b0, $urandom, $urandom);
    end
    wait_idle(sel);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          mag;
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    drive(2, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy0", 32'(bz0), 0);
    check("rst_done0", 32'(dn0), 0);
    check("rst_quotient0", {16'b0, q0}, 0);
    check("rst_remainder1", {16'b0, r1}, 0);
    check("rst_flags2", {30'b0, z2, v2}, 0);
    rst_n = 1'b1;

    op(0, 100, 7, 3);
    op(0, 5, 9, 0);
    op(0, 1234, 0, 0);
    op(1, 32'hFFF9, 2, 0);
    op(1, 7, 32'hFFFE, 0);
    op(2, 32'h80, 32'hFF, 5);

    // Abort 1000/3 with reset in its fifth cycle; no done may appear for it.
    @(posedge clk); #1;
    drive(0, 1'b1, 1000, 3);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(bz0), 0);
    check("abort_quotient", {16'b0, q0}, 0);
    rst_n = 1'b1;
    op(0, 9, 4, 0);
    op(0, 50, 5, 4);

    // start held high: second operation begins on the first IDLE cycle.
    sb.push_back(model(0, 20, 6));
    sb.push_back(model(0, 20, 6));
    @(posedge clk); #1;
    drive(0, 1'b1, 20, 6);
    @(posedge clk); #1;
    wait_idle(0);
    @(posedge clk); #1;
    check("b2b_reaccept", 32'(bz0), 1);
    drive(0, 1'b0, 0, 0);
    wait_idle(0);

    for (int i = 0; i < 12; i++) begin
      rb = (i % 6 == 5) ? 32'd0 : 32'($urandom_range(50, 65535));
      op(0, $urandom_range(0, 65535), rb, $urandom_range(0, 3));
    end
    for (int i = 0; i < 12; i++) begin
      mag = $urandom_range(64, 32767);
      rb  = ($urandom_range(0, 1) == 1) ? 32'(-mag) : 32'(mag);
      op(1, $urandom_range(0, 65535), rb, $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      op(2, ra, rb, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
